riscv_exc_sequencer: RTL and testbench
======================================

Name: riscv_exc_sequencer

Overview:
- Trap-request sequencer between the ID-stage exception sources, the core controller and the CSR block.
- Prioritises synchronous exceptions and the 32 interrupt lines, and holds one registered trap request with a cause until the controller acknowledges it.
- After acknowledge it issues the one-cycle cause/save strobes the CSR block consumes. It also turns a retired eret into the mstatus restore strobe.

Parameters:
- N_IRQ, 32, number of interrupt lines; fixed at 32 (cause field is 5 bits).
- IRQ_BITS, 5, log2(N_IRQ), width of the interrupt index.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- irq_i  in  N_IRQ  level interrupt lines; bit 0 is highest priority
- irq_enable_i  in  1  global interrupt enable (mstatus IE from the CSR block)
- lsu_err_i  in  1  load/store access error reported from EX (single-cycle)
- illegal_insn_i  in  1  illegal instruction in ID
- ebrk_insn_i  in  1  ebreak in ID
- ecall_insn_i  in  1  ecall in ID
- eret_insn_i  in  1  eret in ID
- id_valid_i  in  1  ID stage retires its instruction this cycle
- ctrl_ack_i  in  1  controller accepts the pending trap
- req_o  out  1  trap request pending
- req_is_irq_o  out  1  pending request is an interrupt
- cause_o  out  6  {is_irq, code[4:0]}; to exc_cause_i of the CSR block
- save_cause_o  out  1  one-cycle strobe; to save_exc_cause_i
- save_id_o  out  1  one-cycle strobe, save ID pc to mepc; to exc_save_id_i
- restore_o  out  1  one-cycle strobe, mstatus restore; to exc_restore_i

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE. All outputs are 0 and cause_o=6'h00; restore_o and the strobes are cleared immediately.
- Cause codes:
  - lsu_err 6'h05
  - illegal 6'h02
  - ebreak 6'h03
  - ecall 6'h0B
  - interrupt {1'b1, idx}, where idx is the lowest set bit of irq_i
- Priority, highest first: lsu_err > illegal > ebreak > ecall > interrupt.
- Synchronous exceptions are never masked. Interrupts are considered only when irq_enable_i=1 and irq_i is nonzero.
- FSM state IDLE:
  - Any qualifying event in cycle N → cause registered, state REQ.
  - req_o=1 from cycle N+1; latency is 1 cycle.
- FSM state REQ:
  - req_o=1; cause_o is stable while the request stays an exception.
  - Upgrade: if req_is_irq_o=1 and a synchronous exception arrives before ack, cause is replaced by the exception cause and req_is_irq_o drops; req_o stays 1.
  - Withdrawal: if req_is_irq_o=1 and the interrupt condition vanishes before ack (the line drops or irq_enable_i=0), the request is cancelled and the FSM returns to IDLE. A lower-priority interrupt that is still set is re-evaluated in IDLE on the next cycle.
  - A higher-priority interrupt arriving while in REQ does NOT change the cause.
  - ctrl_ack_i=1 → state SAVE; this wins over an upgrade or withdrawal in the same cycle.
- FSM state SAVE (one cycle):
  - save_cause_o=1 and save_id_o=1; cause_o keeps the accepted value; req_o=0.
  - Next state is IDLE.
- Events arriving while in SAVE are ignored; sources are required to hold until re-sampled in IDLE.
- eret: eret_insn_i & id_valid_i in IDLE with no qualifying trap event in the same cycle → restore_o=1 for exactly the next cycle.
  - eret outside IDLE, or coinciding with a trap event, is ignored; the trap wins.
- ctrl_ack_i is ignored outside REQ.
- Back-to-back traps: in the IDLE cycle after SAVE a new event is accepted, so req_o can reassert 2 cycles after ack.

Optional Feature:
- Macro DIFT_TRAP_EN.
- When defined, two extra inputs are added:
  - tag_viol_i (1): DIFT tag check failed
  - tag_trap_en_i (1): trap enable bit from the TCR
- tag_viol_i & tag_trap_en_i raises cause 6'h18, prioritised below lsu_err and above illegal. It is never masked by irq_enable_i.
- When undefined, both ports are absent and cause 6'h18 is never produced.

Decomposition:
- riscv_defines package:
  - constants EXC_CAUSE_LSU_ERR, EXC_CAUSE_ILLEGAL, EXC_CAUSE_EBREAK, EXC_CAUSE_ECALL, EXC_CAUSE_TAG_VIOL
  - enum exc_seq_state_t {EXC_IDLE, EXC_REQ, EXC_SAVE}
- Sub-module riscv_irq_prio_enc: a 32-to-5 lowest-index-first priority encoder with a valid output, instantiated once.

Test Plan:
- irq_i=32'h0000_0090, irq_enable_i=1 → req_o=1 next cycle, cause_o=6'h24; ack → save_cause_o and save_id_o pulse 1 cycle, then req_o=0.
- REQ holding cause 6'h24, then illegal_insn_i=1 before ack → cause_o=6'h02, req_is_irq_o=0; ack → strobes with 6'h02.
- REQ holding cause 6'h24, then irq_i returns to 0 with no ack → req_o=0 next cycle and no strobes.
- lsu_err_i, illegal_insn_i and ecall_insn_i asserted in the same cycle with irq_enable_i=0 and irq_i=FFFF_FFFF → cause_o=6'h05.
- eret_insn_i=1, id_valid_i=1 in IDLE → restore_o=1 for exactly one cycle. eret together with ecall → restore_o stays 0 and cause_o=6'h0B.
- rst_n dropped while in REQ → req_o=0 immediately; after release the FSM is in IDLE. With DIFT_TRAP_EN: tag_viol_i=1 and tag_trap_en_i=1 together with illegal_insn_i → cause_o=6'h18.

Source files
------------

// File: rtl/riscv_defines.sv
// riscv_defines: shared constants and types for the exception sequencer.
//   N_IRQ / IRQ_BITS      - interrupt line count and index width
//   EXC_CAUSE_*           - 6-bit mcause values {is_irq, code[4:0]}
//   exc_seq_state_t       - trap sequencer FSM states
package riscv_defines;

   localparam int unsigned N_IRQ    = 32;
   localparam int unsigned IRQ_BITS = 5;

   localparam logic [5:0] EXC_CAUSE_LSU_ERR  = 6'h05;
   localparam logic [5:0] EXC_CAUSE_ILLEGAL  = 6'h02;
   localparam logic [5:0] EXC_CAUSE_EBREAK   = 6'h03;
   localparam logic [5:0] EXC_CAUSE_ECALL    = 6'h0B;
   localparam logic [5:0] EXC_CAUSE_TAG_VIOL = 6'h18;

   typedef enum logic [1:0] {
      EXC_IDLE,
      EXC_REQ,
      EXC_SAVE
   } exc_seq_state_t;

endpackage

// File: rtl/riscv_irq_prio_enc.sv
// riscv_irq_prio_enc: lowest-index-first priority encoder.
//   req_i   [N-1:0]  request lines, bit 0 highest priority
//   idx_o   [W-1:0]  index of the lowest set bit (0 when none set)
//   valid_o          at least one request line set
module riscv_irq_prio_enc #(
   parameter int unsigned N = 32,
   parameter int unsigned W = 5
) (
   input  logic [N-1:0] req_i,
   output logic [W-1:0] idx_o,
   output logic         valid_o
);

   // Scan from the top down so the lowest set index is written last.
   always_comb begin
      idx_o   = '0;
      valid_o = |req_i;
      for (int unsigned i = N; i > 0; i--) begin
         if (req_i[i-1]) idx_o = W'(i - 1);
      end
   end

endmodule

// File: rtl/riscv_exc_sequencer.sv
// riscv_exc_sequencer: trap-request sequencer between ID exception sources,
// the core controller and the CSR block.
//   irq_i / irq_enable_i     level interrupts (bit 0 highest) and global enable
//   lsu_err_i, illegal_insn_i, ebrk_insn_i, ecall_insn_i  synchronous exceptions
//   eret_insn_i / id_valid_i retired eret -> restore_o one cycle later
//   ctrl_ack_i               controller accepts the pending request
//   req_o / req_is_irq_o     pending request and its kind
//   cause_o                  {is_irq, code[4:0]} for the CSR block
//   save_cause_o / save_id_o one-cycle strobes after acknowledge
//   restore_o                one-cycle mstatus restore strobe
// Optional: define DIFT_TRAP_EN to add tag_viol_i / tag_trap_en_i, which raise
// cause 6'h18 between lsu_err and illegal in priority.
module riscv_exc_sequencer
   import riscv_defines::*;
#(
   parameter int unsigned N_IRQ    = 32,
   parameter int unsigned IRQ_BITS = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_IRQ-1:0] irq_i,
   input  logic             irq_enable_i,
   input  logic             lsu_err_i,
   input  logic             illegal_insn_i,
   input  logic             ebrk_insn_i,
   input  logic             ecall_insn_i,
   input  logic             eret_insn_i,
   input  logic             id_valid_i,
   input  logic             ctrl_ack_i,
`ifdef DIFT_TRAP_EN
   input  logic             tag_viol_i,
   input  logic             tag_trap_en_i,
`endif
   output logic             req_o,
   output logic             req_is_irq_o,
   output logic [5:0]       cause_o,
   output logic             save_cause_o,
   output logic             save_id_o,
   output logic             restore_o
);

   exc_seq_state_t state_q, state_d;
   logic [5:0]     cause_q, cause_d;
   logic           restore_q, restore_d;

   logic [IRQ_BITS-1:0] irq_idx;
   logic                irq_any;
   logic                irq_valid;
   logic                exc_valid;
   logic [5:0]          exc_cause;
   logic                held_irq_live;

   riscv_irq_prio_enc #(
      .N (N_IRQ),
      .W (IRQ_BITS)
   ) u_irq_prio_enc (
      .req_i   (irq_i),
      .idx_o   (irq_idx),
      .valid_o (irq_any)
   );

   assign irq_valid = irq_enable_i & irq_any;

   // Sources are listed lowest priority first; the last match wins.
   always_comb begin
      exc_valid = 1'b0;
      exc_cause = '0;
      if (ecall_insn_i) begin
         exc_valid = 1'b1;
         exc_cause = EXC_CAUSE_ECALL;
      end
      if (ebrk_insn_i) begin
         exc_valid = 1'b1;
         exc_cause = EXC_CAUSE_EBREAK;
      end
      if (illegal_insn_i) begin
         exc_valid = 1'b1;
         exc_cause = EXC_CAUSE_ILLEGAL;
      end
`ifdef DIFT_TRAP_EN
      if (tag_viol_i & tag_trap_en_i) begin
         exc_valid = 1'b1;
         exc_cause = EXC_CAUSE_TAG_VIOL;
      end
`endif
      if (lsu_err_i) begin
         exc_valid = 1'b1;
         exc_cause = EXC_CAUSE_LSU_ERR;
      end
   end

   // The held interrupt is withdrawn only when its own line (or the enable)
   // drops; other lines are picked up again from IDLE.
   assign held_irq_live = irq_enable_i & irq_i[cause_q[IRQ_BITS-1:0]];

   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      restore_d = 1'b0;
      unique case (state_q)
         EXC_IDLE: begin
            if (exc_valid) begin
               cause_d = exc_cause;
               state_d = EXC_REQ;
            end else if (irq_valid) begin
               cause_d = {1'b1, irq_idx};
               state_d = EXC_REQ;
            end else if (eret_insn_i & id_valid_i) begin
               restore_d = 1'b1;
            end
         end
         EXC_REQ: begin
            if (ctrl_ack_i) begin
               state_d = EXC_SAVE;
            end else if (cause_q[5] & exc_valid) begin
               cause_d = exc_cause;
            end else if (cause_q[5] & ~held_irq_live) begin
               cause_d = '0;
               state_d = EXC_IDLE;
            end
         end
         EXC_SAVE: begin
            cause_d = '0;
            state_d = EXC_IDLE;
         end
         default: begin
            cause_d = '0;
            state_d = EXC_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= EXC_IDLE;
         cause_q   <= '0;
         restore_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cause_q   <= cause_d;
         restore_q <= restore_d;
      end
   end

   assign req_o        = (state_q == EXC_REQ);
   assign req_is_irq_o = (state_q == EXC_REQ) & cause_q[5];
   assign cause_o      = cause_q;
   assign save_cause_o = (state_q == EXC_SAVE);
   assign save_id_o    = (state_q == EXC_SAVE);
   assign restore_o    = restore_q;

endmodule

// File: tb/tb_riscv_exc_sequencer.sv
// Scoreboard bench for riscv_exc_sequencer: the driver pushes expected output
// events (kind, value, cycle); the monitor turns DUT output changes into events
// and pops/compares them.
module tb_riscv_exc_sequencer;

   localparam int K_REQ = 0;   // req_o rises: val = {0, is_irq, cause}
   localparam int K_UPG = 1;   // cause changes while req_o held
   localparam int K_SAV = 2;   // save strobes: val = {save_cause, save_id, cause}
   localparam int K_RST = 3;   // restore_o: val = 0
   localparam int K_WDR = 4;   // req_o falls without strobes: val = 0

   typedef struct {
      int         kind;
      logic [7:0] val;
      int         cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] irq_i = '0;
   logic        irq_enable_i = 1'b0;
   logic        lsu_err_i = 1'b0, illegal_insn_i = 1'b0, ebrk_insn_i = 1'b0;
   logic        ecall_insn_i = 1'b0, eret_insn_i = 1'b0, id_valid_i = 1'b0;
   logic        ctrl_ack_i = 1'b0;
   logic        tag_viol_i = 1'b0, tag_trap_en_i = 1'b0;
   logic        req_o, req_is_irq_o, save_cause_o, save_id_o, restore_o;
   logic [5:0]  cause_o;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   always #5 clk = ~clk;

   riscv_exc_sequencer #(.N_IRQ(32), .IRQ_BITS(5)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .irq_i          (irq_i),
      .irq_enable_i   (irq_enable_i),
      .lsu_err_i      (lsu_err_i),
      .illegal_insn_i (illegal_insn_i),
      .ebrk_insn_i    (ebrk_insn_i),
      .ecall_insn_i   (ecall_insn_i),
      .eret_insn_i    (eret_insn_i),
      .id_valid_i     (id_valid_i),
      .ctrl_ack_i     (ctrl_ack_i),
`ifdef DIFT_TRAP_EN
      .tag_viol_i     (tag_viol_i),
      .tag_trap_en_i  (tag_trap_en_i),
`endif
      .req_o          (req_o),
      .req_is_irq_o   (req_is_irq_o),
      .cause_o        (cause_o),
      .save_cause_o   (save_cause_o),
      .save_id_o      (save_id_o),
      .restore_o      (restore_o)
   );

   // ---------------- monitor ----------------
   task automatic check_event(input int kind, input logic [7:0] val);
      exp_t e;
      total++;
      if (q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event cyc=%0d got kind=%0d val=%h, required none", cyc, kind, val);
      end else begin
         e = q.pop_front();
         if (e.kind != kind || e.val != val || e.cyc != cyc) begin
            bad++;
            $display("FAIL event got kind=%0d val=%h cyc=%0d, required kind=%0d val=%h cyc=%0d",
                     kind, val, cyc, e.kind, e.val, e.cyc);
         end
      end
   endtask

   initial begin : monitor
      logic       prev_req;
      logic [5:0] prev_cause;
      prev_req   = 1'b0;
      prev_cause = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (save_cause_o | save_id_o)
            check_event(K_SAV, {save_cause_o, save_id_o, cause_o});
         if (restore_o)
            check_event(K_RST, 8'h00);
         if (req_o && !prev_req)
            check_event(K_REQ, {1'b0, req_is_irq_o, cause_o});
         else if (req_o && prev_req && cause_o != prev_cause)
            check_event(K_UPG, {1'b0, req_is_irq_o, cause_o});
         if (!req_o && prev_req && !(save_cause_o | save_id_o))
            check_event(K_WDR, 8'h00);
         prev_req   = req_o;
         prev_cause = cause_o;
      end
   end

   // ---------------- driver ----------------
   task automatic expect_ev(input int kind, input logic [7:0] val, input int dly);
      exp_t e;
      e.kind = kind;
      e.val  = val;
      e.cyc  = cyc + dly;
      q.push_back(e);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic clr();
      irq_i = '0; irq_enable_i = 1'b0; lsu_err_i = 1'b0; illegal_insn_i = 1'b0;
      ebrk_insn_i = 1'b0; ecall_insn_i = 1'b0; eret_insn_i = 1'b0;
      id_valid_i = 1'b0; ctrl_ack_i = 1'b0; tag_viol_i = 1'b0; tag_trap_en_i = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         clr();
      end
   endtask

   initial begin : driver
      #3;
      total++;
      if ({req_o, req_is_irq_o, cause_o, save_cause_o, save_id_o, restore_o} != '0) begin
         bad++;
         $display("FAIL reset_outputs got req=%b irq=%b cause=%h sc=%b sid=%b rs=%b, required all 0",
                  req_o, req_is_irq_o, cause_o, save_cause_o, save_id_o, restore_o);
      end
      step(); step();
      rst_n = 1'b1;
      idle(2);

      // Interrupt, ack, back-to-back reassert, then withdrawal by line drop
      step(); irq_i = 32'h0000_0090; irq_enable_i = 1'b1;
      expect_ev(K_REQ, 8'h64, 1);
      step(); ctrl_ack_i = 1'b1;
      expect_ev(K_SAV, 8'hE4, 1);
      step(); ctrl_ack_i = 1'b0;
      expect_ev(K_REQ, 8'h64, 2);
      step();
      step(); irq_i = '0;
      expect_ev(K_WDR, 8'h00, 1);
      idle(3);

      // Upgrade to illegal, ack in the next cycle
      step(); irq_i = 32'h0000_0090; irq_enable_i = 1'b1;
      expect_ev(K_REQ, 8'h64, 1);
      step(); illegal_insn_i = 1'b1;
      expect_ev(K_UPG, 8'h02, 1);
      step(); ctrl_ack_i = 1'b1;
      expect_ev(K_SAV, 8'hC2, 1);
      idle(3);

      // Exception priority with interrupts masked
      step(); lsu_err_i = 1'b1; illegal_insn_i = 1'b1; ecall_insn_i = 1'b1;
      irq_i = 32'hFFFF_FFFF; irq_enable_i = 1'b0;
      expect_ev(K_REQ, 8'h05, 1);
      step(); clr(); ctrl_ack_i = 1'b1;
      expect_ev(K_SAV, 8'hC5, 1);
      idle(3);

      // ebreak alone
      step(); ebrk_insn_i = 1'b1;
      expect_ev(K_REQ, 8'h03, 1);
      step(); clr(); ctrl_ack_i = 1'b1;
      expect_ev(K_SAV, 8'hC3, 1);
      idle(3);

      // eret restore, one cycle
      step(); eret_insn_i = 1'b1; id_valid_i = 1'b1;
      expect_ev(K_RST, 8'h00, 1);
      idle(3);

      // eret together with ecall: trap wins
      step(); eret_insn_i = 1'b1; id_valid_i = 1'b1; ecall_insn_i = 1'b1;
      expect_ev(K_REQ, 8'h0B, 1);
      step(); clr(); ctrl_ack_i = 1'b1;
      expect_ev(K_SAV, 8'hCB, 1);
      idle(3);

      // Higher-priority interrupt in REQ keeps cause
      step(); irq_i = 32'h0000_0010; irq_enable_i = 1'b1;
      expect_ev(K_REQ, 8'h64, 1);
      step(); irq_i = 32'h0000_0011;
      step();
      step(); ctrl_ack_i = 1'b1;
      expect_ev(K_SAV, 8'hE4, 1);
      idle(3);

      // Withdrawal by irq_enable_i drop
      step(); irq_i = 32'h0000_0004; irq_enable_i = 1'b1;
      expect_ev(K_REQ, 8'h62, 1);
      step(); irq_enable_i = 1'b0;
      expect_ev(K_WDR, 8'h00, 1);
      idle(3);

      // Held line drops, lower-priority line re-evaluated from IDLE
      step(); irq_i = 32'h0000_0010; irq_enable_i = 1'b1;
      expect_ev(K_REQ, 8'h64, 1);
      step(); irq_i = 32'h0000_0020;
      expect_ev(K_WDR, 8'h00, 1);
      expect_ev(K_REQ, 8'h65, 2);
      step();
      step(); ctrl_ack_i = 1'b1;
      expect_ev(K_SAV, 8'hE5, 1);
      idle(3);

      // Reset while in REQ, then IDLE behaviour after release
      step(); illegal_insn_i = 1'b1;
      expect_ev(K_REQ, 8'h02, 1);
      step(); clr(); rst_n = 1'b0;
      #1;
      total++;
      if (req_o !== 1'b0) begin
         bad++;
         $display("FAIL async_reset_req got req=%b, required 0", req_o);
      end
      expect_ev(K_WDR, 8'h00, 1);
      step(); rst_n = 1'b1;
      step(); ecall_insn_i = 1'b1;
      expect_ev(K_REQ, 8'h0B, 1);
      step(); clr(); ctrl_ack_i = 1'b1;
      expect_ev(K_SAV, 8'hCB, 1);
      idle(3);

`ifdef DIFT_TRAP_EN
      step(); tag_viol_i = 1'b1; tag_trap_en_i = 1'b1; illegal_insn_i = 1'b1;
      expect_ev(K_REQ, 8'h18, 1);
      step(); clr(); ctrl_ack_i = 1'b1;
      expect_ev(K_SAV, 8'hD8, 1);
      idle(3);
`endif

      idle(4);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL pending_expectations got %0d left, required 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
